// File: rtl/regfile_reader_pkg.sv
// Shared types and constants for the RegFile2 read-back scanner.
package regfile_reader_pkg;

  localparam int unsigned DataW   = 16;
  localparam int unsigned RegSelW = 4;

  typedef logic [RegSelW-1:0] reg_sel_t;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSample,
    StShow,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_reader_if.sv
// RegFile2 read-port pair (A/B) shared with the Fibonacci sequencer.
interface regfile_reader_if
  import regfile_reader_pkg::*;
#(
  parameter int unsigned DataWidth = regfile_reader_pkg::DataW
) ();

  reg_sel_t             sel_a;
  reg_sel_t             sel_b;
  logic [DataWidth-1:0] a;
  logic [DataWidth-1:0] b;

  modport master (output sel_a, output sel_b, input a, input b);
  modport slave  (input sel_a, input sel_b, output a, output b);

endinterface

// File: rtl/regfile_reader_fib_check.sv
// fib_check_unit: Fibonacci-recurrence and A/B port agreement check with a
// sticky flag that latches the index of the first failing entry.
module fib_check_unit
  import regfile_reader_pkg::*;
#(
  parameter int unsigned DataWidth = regfile_reader_pkg::DataW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 sample_i,
  input  reg_sel_t             idx_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] prev1_i,
  input  logic [DataWidth-1:0] prev2_i,
  output logic                 mismatch_o,
  output reg_sel_t             mismatch_index_o
);

  logic [DataWidth-1:0] sum;
  logic                 fail;
  logic                 mismatch_d, mismatch_q;
  reg_sel_t             index_d, index_q;

  // Carry is dropped: the recurrence is checked modulo 2^DataWidth.
  assign sum  = prev1_i + prev2_i;
  assign fail = sample_i && (((idx_i >= reg_sel_t'(2)) && (sum != a_i)) || (b_i != a_i));

  always_comb begin
    mismatch_d = mismatch_q;
    index_d    = index_q;
    if (clear_i) begin
      mismatch_d = 1'b0;
      index_d    = '0;
    end else if (fail && !mismatch_q) begin
      mismatch_d = 1'b1;
      index_d    = idx_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
      index_q    <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      index_q    <= index_d;
    end
  end

  assign mismatch_o       = mismatch_q;
  assign mismatch_index_o = index_q;

endmodule

// File: rtl/regfile_reader.sv
// Walks RegFile2 entries 0..NumRegs-1, presenting each index/value for a fixed dwell.
// Define FIB_CHECK_EN to add the Fibonacci integrity check (fib_check_unit).
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int unsigned NumRegs     = 16,
  parameter int unsigned DataWidth   = regfile_reader_pkg::DataW,
  parameter int unsigned DwellCycles = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  regfile_reader_if.master     rf_io,
  output reg_sel_t             read_index_o,
  output logic [DataWidth-1:0] read_value_o,
  output logic                 value_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mismatch_o,
  output reg_sel_t             mismatch_index_o
);

  localparam int unsigned CntW      = $clog2(DwellCycles + 1);
  localparam reg_sel_t    LastIdx   = reg_sel_t'(NumRegs - 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(DwellCycles - 1);

  state_e               state_d, state_q;
  reg_sel_t             idx_d, idx_q;
  logic [CntW-1:0]      cnt_d, cnt_q;
  reg_sel_t             read_index_d, read_index_q;
  logic [DataWidth-1:0] read_value_d, read_value_q;
  logic [DataWidth-1:0] prev1_d, prev1_q, prev2_d, prev2_q;
  logic                 launch;

  assign launch = start_i && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    read_index_d = read_index_q;
    read_value_d = read_value_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StAddr;
          idx_d   = '0;
        end
      end
      StAddr: state_d = StSample;
      StSample: begin
        read_value_d = rf_io.a;
        read_index_d = idx_q;
        cnt_d        = DwellLoad;
        prev2_d      = prev1_q;
        prev1_d      = rf_io.a;
        state_d      = StShow;
      end
      StShow: begin
        if (cnt_q == '0) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StAddr;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      read_index_q <= '0;
      read_value_q <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      read_index_q <= read_index_d;
      read_value_q <= read_value_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
    end
  end

  // Select is held through ADDR and SAMPLE so registered reads also land in SAMPLE.
  assign rf_io.sel_a   = idx_q;
  assign rf_io.sel_b   = idx_q;
  assign read_index_o  = read_index_q;
  assign read_value_o  = read_value_q;
  assign value_valid_o = (state_q == StShow);
  assign busy_o        = (state_q == StAddr) || (state_q == StSample) || (state_q == StShow);
  assign done_o        = (state_q == StDone);

`ifdef FIB_CHECK_EN
  fib_check_unit #(
    .DataWidth(DataWidth)
  ) u_fib_check (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (launch),
    .sample_i        (state_q == StSample),
    .idx_i           (idx_q),
    .a_i             (rf_io.a),
    .b_i             (rf_io.b),
    .prev1_i         (prev1_q),
    .prev2_i         (prev2_q),
    .mismatch_o      (mismatch_o),
    .mismatch_index_o(mismatch_index_o)
  );
`else
  logic unused_chk;
  assign unused_chk       = ^{prev1_q, prev2_q, rf_io.b, launch};
  assign mismatch_o       = 1'b0;
  assign mismatch_index_o = '0;
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: scan timing, dwell, restart rules, reset and the check.
module tb_regfile_reader;

  localparam int NumRegs    = 16;
  localparam int Dwell      = 6;
  localparam int ScanCycles = NumRegs * (Dwell + 2) + 1;
`ifdef FIB_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  read_index;
  logic [15:0] read_value;
  logic        valid, busy, done, mismatch;
  logic [3:0]  mismatch_index;
  logic [15:0] mem [NumRegs];
  logic        b_flip_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  regfile_reader_if #(.DataWidth(16)) rf_if ();

  assign rf_if.a = mem[rf_if.sel_a];
  assign rf_if.b = mem[rf_if.sel_b] ^ {15'd0, (b_flip_en && (rf_if.sel_b == 4'd3))};

  regfile_reader #(
    .NumRegs    (NumRegs),
    .DataWidth  (16),
    .DwellCycles(Dwell)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .rf_io           (rf_if),
    .read_index_o    (read_index),
    .read_value_o    (read_value),
    .value_valid_o   (valid),
    .busy_o          (busy),
    .done_o          (done),
    .mismatch_o      (mismatch),
    .mismatch_index_o(mismatch_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic end_entry(input int entry, input int cur, input int run);
    check_eq($sformatf("entry%0d_index", entry), cur, entry);
    check_eq($sformatf("entry%0d_dwell", entry), run, Dwell);
    check_eq($sformatf("entry%0d_value", entry), read_value, mem[entry]);
  endtask

  // Pulse Start, follow the whole scan at negedges, optionally poke Start at poke_idx.
  task automatic run_scan(input int poke_idx);
    int n, run, cur, entry;
    bit poked;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("done_after_start", done, 0);
    n = 1; run = 0; cur = 0; entry = 0; poked = 1'b0;
    while (n < 2 * ScanCycles) begin
      start = 1'b0;
      if (done) break;
      if (valid) begin
        cur = read_index;
        run++;
        if ((int'(read_index) == poke_idx) && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end else if (run > 0) begin
        end_entry(entry, cur, run);
        entry++;
        run = 0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (run > 0) begin
      end_entry(entry, cur, run);
      entry++;
    end
    check_eq("scan_cycles", n, ScanCycles);
    check_eq("entries", entry, NumRegs);
    check_eq("done_set", done, 1);
    check_eq("busy_clear", busy, 0);
    check_eq("valid_in_done", valid, 0);
    check_eq("hold_index", read_index, NumRegs - 1);
    check_eq("hold_value", read_value, mem[NumRegs-1]);
  endtask

  task automatic check_mm(input string tag, input bit exp_mm, input int exp_idx);
    check_eq({tag, "_mismatch"}, mismatch, exp_mm);
    check_eq({tag, "_mm_index"}, mismatch_index, exp_idx);
  endtask

  initial begin
    for (int i = 0; i < NumRegs; i++) mem[i] = 16'(3 * i);

    repeat (2) @(negedge clk);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_index", read_index, 0);
    check_eq("rst_value", read_value, 0);
    check_eq("rst_sel", rf_if.sel_a, 0);
    check_mm("rst", 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);

    // R[i]=3i: 0+3 != 6 trips the check at index 2 when enabled.
    run_scan(-1);
    check_mm("times3", ChkEn, ChkEn ? 2 : 0);
    // Restart from DONE, Start poked mid-scan at index 4 must be ignored.
    run_scan(4);
    check_mm("times3_rerun", ChkEn, ChkEn ? 2 : 0);

    // Wrap: 0xFFFF+2 = 1 passes; R7 corrupted to 0.
    mem[0] = 16'hFFFF; mem[1] = 16'd2; mem[2] = 16'd1; mem[3] = 16'd3;
    mem[4] = 16'd4;    mem[5] = 16'd7; mem[6] = 16'd11; mem[7] = 16'd0;
    for (int i = 8; i < NumRegs; i++) mem[i] = mem[i-1] + mem[i-2];
    run_scan(-1);
    check_mm("wrap", ChkEn, ChkEn ? 7 : 0);

    mem[0] = 16'd1; mem[1] = 16'd1;
    for (int i = 2; i < NumRegs; i++) mem[i] = mem[i-1] + mem[i-2];
    run_scan(-1);
    check_eq("fib_last", read_value, 987);
    check_mm("fib", 1'b0, 0);

    b_flip_en = 1'b1;
    run_scan(-1);
    check_mm("bflip", ChkEn, ChkEn ? 3 : 0);
    b_flip_en = 1'b0;

    // Asynchronous reset while showing entry 5.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid && (read_index == 4'd5)) break;
      @(negedge clk);
    end
    check_eq("reach_idx5", {valid, read_index}, {1'b1, 4'd5});
    rst = 1'b1;
    #1;
    check_eq("arst_valid", valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_index", read_index, 0);
    check_eq("arst_value", read_value, 0);
    check_eq("arst_sel", rf_if.sel_a, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("idle_valid", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
